// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter, LSB first, fed by a small valid/ready byte FIFO.
// Queued bytes go out back-to-back with no idle cycles between frames.
module uart_transmitter #(
    parameter int unsigned CLKS_PER_BIT = 9,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned BIT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [BIT_W-1:0] BIT_LAST     = BIT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_PRE_LAST = BIT_W'(CLKS_PER_BIT - 2);
    localparam logic [CNT_W-1:0] CNT_FULL     = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state;
    logic [BIT_W-1:0] bit_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift_reg;

    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic             push;
    logic             pop;
    logic             bit_end;

    // Handshake, pop decision and next FIFO occupancy
    always_comb begin
        bit_end    = (bit_cnt == BIT_LAST);
        push       = tx_valid && tx_ready;
        pop        = (count != '0) && ((state == IDLE) || ((state == STOP) && bit_end));
        count_next = count;
        if (push && !pop) begin
            count_next = count + CNT_W'(1);
        end else if (pop && !push) begin
            count_next = count - CNT_W'(1);
        end
    end

    // FIFO storage; contents need no reset since occupancy is tracked by count
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wr_ptr] <= tx_data;
        end
    end

    // FIFO pointers, occupancy and registered ready (not full)
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            tx_ready <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count    <= count_next;
            tx_ready <= (count_next != CNT_FULL);
        end
    end

    // Frame sequencer: start bit, 8 data bits LSB first, stop bit
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            tx        <= 1'b1;
            tx_busy   <= 1'b0;
            tx_done   <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            case (state)
                IDLE: begin
                    bit_cnt <= '0;
                    bit_idx <= '0;
                    if (pop) begin
                        shift_reg <= fifo_mem[rd_ptr];
                        state     <= START;
                        tx        <= 1'b0;
                        tx_busy   <= 1'b1;
                    end else begin
                        tx      <= 1'b1;
                        tx_busy <= 1'b0;
                    end
                end
                START: begin
                    if (bit_end) begin
                        bit_cnt   <= '0;
                        bit_idx   <= '0;
                        tx        <= shift_reg[0];
                        shift_reg <= {1'b0, shift_reg[7:1]};
                        state     <= DATA;
                    end else begin
                        bit_cnt <= bit_cnt + BIT_W'(1);
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        bit_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            bit_idx   <= bit_idx + 3'd1;
                            tx        <= shift_reg[0];
                            shift_reg <= {1'b0, shift_reg[7:1]};
                        end
                    end else begin
                        bit_cnt <= bit_cnt + BIT_W'(1);
                    end
                end
                STOP: begin
                    // Raise done on entry to the last stop cycle so it is high during it
                    if (bit_cnt == BIT_PRE_LAST) begin
                        tx_done <= 1'b1;
                    end
                    if (bit_end) begin
                        bit_cnt <= '0;
                        bit_idx <= '0;
                        if (pop) begin
                            shift_reg <= fifo_mem[rd_ptr];
                            tx        <= 1'b0;
                            state     <= START;
                        end else begin
                            tx      <= 1'b1;
                            tx_busy <= 1'b0;
                            state   <= IDLE;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + BIT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: frame-exact waveform table plus a serial-decoding
// scoreboard, on a 9-clock/4-deep instance (a_*) and a 2-clock/2-deep one (b_*).
module tb_uart_transmitter;

    logic       clock;
    logic       reset;
    logic [7:0] a_data;
    logic       a_valid;
    logic       a_ready;
    logic       a_tx;
    logic       a_busy;
    logic       a_done;
    logic [7:0] b_data;
    logic       b_valid;
    logic       b_ready;
    logic       b_tx;
    logic       b_busy;
    logic       b_done;

    uart_transmitter #(.CLKS_PER_BIT(9), .FIFO_DEPTH(4)) dut_a (
        .clock    (clock),
        .reset    (reset),
        .tx_data  (a_data),
        .tx_valid (a_valid),
        .tx_ready (a_ready),
        .tx       (a_tx),
        .tx_busy  (a_busy),
        .tx_done  (a_done)
    );

    uart_transmitter #(.CLKS_PER_BIT(2), .FIFO_DEPTH(2)) dut_b (
        .clock    (clock),
        .reset    (reset),
        .tx_data  (b_data),
        .tx_valid (b_valid),
        .tx_ready (b_ready),
        .tx       (b_tx),
        .tx_busy  (b_busy),
        .tx_done  (b_done)
    );

    typedef struct {
        logic [7:0] data;
        logic [0:9] frame;
    } vec_t;

    vec_t       vec [8];
    logic [7:0] q_a [$];
    logic [7:0] q_b [$];
    int         nvec = 0;
    int         nmis = 0;
    int         rst_cnt = 0;

    bit         acc;
    bit         dn;
    bit         found;
    bit         bad;
    bit         rh [100];
    bit         dh [100];
    int         acc_n;
    int         first_done;
    bit         r0, r1, r2, r3;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) if (reset) rst_cnt <= rst_cnt + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    function automatic logic txs(input int sel);
        return (sel == 0) ? a_tx : b_tx;
    endfunction

    function automatic logic busys(input int sel);
        return (sel == 0) ? a_busy : b_busy;
    endfunction

    function automatic logic dones(input int sel);
        return (sel == 0) ? a_done : b_done;
    endfunction

    task automatic cmp(input string name, input int act, input int expv);
        nvec++;
        if (act !== expv) begin
            nmis++;
            $display("FAIL %s: got %0d, want %0d", name, act, expv);
        end
    endtask

    // Drive one byte for one cycle; acc/dn are ready/done seen just before the edge
    task automatic drive(input int sel, input logic [7:0] d, output bit accepted, output bit done_seen);
        @(negedge clock);
        if (sel == 0) begin
            accepted  = a_ready;
            done_seen = a_done;
            a_data    = d;
            a_valid   = 1'b1;
        end else begin
            accepted  = b_ready;
            done_seen = b_done;
            b_data    = d;
            b_valid   = 1'b1;
        end
        @(posedge clock);
        if (accepted) begin
            if (sel == 0) q_a.push_back(d);
            else          q_b.push_back(d);
        end
    endtask

    task automatic idle_inputs();
        @(negedge clock);
        a_valid = 1'b0;
        b_valid = 1'b0;
    endtask

    task automatic wait_idle(input int sel);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clock);
            if (sel == 0 ? (q_a.size() == 0 && a_busy === 1'b0)
                         : (q_b.size() == 0 && b_busy === 1'b0)) begin
                ok = 1'b1;
                break;
            end
        end
        cmp(sel == 0 ? "drain_a" : "drain_b", int'(ok), 1);
        repeat (3) @(negedge clock);
    endtask

    // Cycle-exact check of n contiguous frames, started alongside the first push
    task automatic check_stream(input int sel, input int first, input int n);
        int         cpb;
        logic [0:9] exp_frame;
        int         bad_bits;
        int         bad_busy;
        int         good_done;
        int         bad_done;
        bit         pre_ok;
        cpb       = (sel == 0) ? 9 : 2;
        bad_bits  = 0;
        bad_busy  = 0;
        good_done = 0;
        bad_done  = 0;
        pre_ok    = 1'b1;
        repeat (2) begin
            @(negedge clock);
            if (txs(sel) !== 1'b1 || busys(sel) !== 1'b0) pre_ok = 1'b0;
        end
        cmp("pre_idle", int'(pre_ok), 1);
        for (int f = 0; f < n; f++) begin
            exp_frame = vec[first + f].frame;
            for (int c = 0; c < 10 * cpb; c++) begin
                @(negedge clock);
                if (txs(sel) !== exp_frame[c / cpb]) bad_bits++;
                if (busys(sel) !== 1'b1) bad_busy++;
                if (dones(sel) === 1'b1) begin
                    if (c == 10 * cpb - 1) good_done++;
                    else                   bad_done++;
                end
            end
        end
        cmp("wave_bits", bad_bits, 0);
        cmp("busy_held", bad_busy, 0);
        cmp("done_pulses", good_done, n);
        cmp("done_misplaced", bad_done, 0);
        @(negedge clock);
        cmp("post_idle", int'({txs(sel), busys(sel), dones(sel)}), int'(3'b100));
    endtask

    // Serial decoder: samples mid-bit and checks each byte against the push order
    task automatic mon(input int sel);
        int         cpb;
        int         snap;
        logic [7:0] b;
        logic [7:0] expb;
        logic       stop_bit;
        cpb = (sel == 0) ? 9 : 2;
        forever begin
            @(negedge clock);
            if (reset === 1'b0 && txs(sel) === 1'b0) begin
                snap = rst_cnt;
                repeat (cpb / 2) @(negedge clock);
                for (int i = 0; i < 8; i++) begin
                    repeat (cpb) @(negedge clock);
                    b[i] = txs(sel);
                end
                repeat (cpb) @(negedge clock);
                stop_bit = txs(sel);
                if (snap == rst_cnt) begin
                    if ((sel == 0 ? q_a.size() : q_b.size()) == 0) begin
                        cmp(sel == 0 ? "mon_a_extra_byte" : "mon_b_extra_byte", int'(b), -1);
                    end else begin
                        expb = (sel == 0) ? q_a.pop_front() : q_b.pop_front();
                        cmp(sel == 0 ? "mon_a_byte" : "mon_b_byte", int'(b), int'(expb));
                        cmp(sel == 0 ? "mon_a_stop" : "mon_b_stop", int'(stop_bit), 1);
                    end
                end
            end
        end
    endtask

    initial begin
        fork
            mon(0);
            mon(1);
        join_none
    end

    initial begin
        vec[0] = '{8'hA5, 10'b0101001011};
        vec[1] = '{8'h00, 10'b0000000001};
        vec[2] = '{8'hFF, 10'b0111111111};
        vec[3] = '{8'h55, 10'b0101010101};
        vec[4] = '{8'h80, 10'b0000000011};
        vec[5] = '{8'h01, 10'b0100000001};
        vec[6] = '{8'h3C, 10'b0001111001};
        vec[7] = '{8'h7E, 10'b0011111101};

        reset   = 1'b1;
        a_data  = 8'h00;
        a_valid = 1'b0;
        b_data  = 8'h00;
        b_valid = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        cmp("rst_a", int'({a_tx, a_busy, a_done, a_ready}), int'(4'b1001));
        cmp("rst_b", int'({b_tx, b_busy, b_done, b_ready}), int'(4'b1001));
        reset = 1'b0;
        repeat (2) @(negedge clock);

        // Single frames from an idle line, one per table entry
        for (int i = 0; i < 8; i++) begin
            fork
                begin
                    drive(0, vec[i].data, acc, dn);
                    idle_inputs();
                end
                check_stream(0, i, 1);
            join
            cmp("single_accept", int'(acc), 1);
            wait_idle(0);
        end

        // Four bytes pushed on consecutive cycles give four contiguous frames
        fork
            begin
                for (int j = 1; j <= 4; j++) drive(0, vec[j].data, acc, dn);
                idle_inputs();
            end
            check_stream(0, 1, 4);
        join
        wait_idle(0);

        // Hold valid with incrementing data: fill, back-pressure, reopen after pop
        acc_n      = 0;
        first_done = -1;
        for (int k = 0; k < 100; k++) begin
            drive(0, 8'(8'h40 + k), acc, dn);
            rh[k] = acc;
            dh[k] = dn;
            if (acc) acc_n++;
        end
        idle_inputs();
        for (int k = 0; k < 100; k++) begin
            if (dh[k] && first_done < 0) first_done = k;
        end
        cmp("t3_full_after_4", int'({rh[4], rh[5]}), int'(2'b10));
        cmp("t3_first_done", first_done, 91);
        cmp("t3_ready_reopen", int'({rh[91], rh[92], rh[93]}), int'(3'b010));
        cmp("t3_accepted", acc_n, 6);
        wait_idle(0);

        // Push on the tx_done cycle into an empty FIFO: one idle cycle, then start
        drive(0, 8'h96, acc, dn);
        idle_inputs();
        found = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clock);
            if (a_done === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        cmp("t5_done_seen", int'(found), 1);
        acc     = a_ready;
        a_data  = 8'h69;
        a_valid = 1'b1;
        @(posedge clock);
        if (acc) q_a.push_back(8'h69);
        cmp("t5_ready", int'(acc), 1);
        idle_inputs();
        cmp("t5_gap", int'({a_tx, a_busy}), int'(2'b10));
        @(negedge clock);
        cmp("t5_start", int'({a_tx, a_busy}), int'(2'b01));
        wait_idle(0);

        // Reset in bit 3 of a frame with two bytes queued
        drive(0, 8'h11, acc, dn);
        drive(0, 8'h22, acc, dn);
        drive(0, 8'h33, acc, dn);
        idle_inputs();
        repeat (38) @(negedge clock);
        cmp("t4_busy_before", int'({a_busy, a_tx}), int'(2'b10));
        reset = 1'b1;
        @(negedge clock);
        cmp("t4_after_reset", int'({a_tx, a_busy, a_ready, a_done}), int'(4'b1010));
        reset = 1'b0;
        q_a.delete();
        q_b.delete();
        bad = 1'b0;
        repeat (100) begin
            @(negedge clock);
            if (a_tx !== 1'b1 || a_done !== 1'b0 || a_busy !== 1'b0) bad = 1'b1;
        end
        cmp("t4_flushed", int'(bad), 0);
        fork
            begin
                drive(0, vec[0].data, acc, dn);
                idle_inputs();
            end
            check_stream(0, 0, 1);
        join
        wait_idle(0);

        // Two clocks per bit, two-deep FIFO
        fork
            begin
                drive(1, vec[6].data, acc, dn);
                idle_inputs();
            end
            check_stream(1, 6, 1);
        join
        wait_idle(1);
        drive(1, 8'hC1, r0, dn);
        drive(1, 8'hC2, r1, dn);
        drive(1, 8'hC3, r2, dn);
        drive(1, 8'hC4, r3, dn);
        idle_inputs();
        cmp("t6_ready_pattern", int'({r0, r1, r2, r3}), int'(4'b1110));
        wait_idle(1);

        cmp("q_a_leftover", q_a.size(), 0);
        cmp("q_b_leftover", q_b.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
